// File: rtl/bus_interface_unit_if.sv
// bus_interface_unit_if: core-side single-beat request/response channel of the bus interface unit
interface bus_interface_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_fetch;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_fetch, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_fetch, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bus_interface_unit.sv
// bus_interface_unit: registered pin-level bus cycles with RDY wait states plus IRQ/NMI/SO synchronisers
module bus_interface_unit #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int STALL_WRITES = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    bus_interface_unit_if.slave core,
    input  logic              RDY,
    input  logic              IRQ,
    input  logic              NMI,
    input  logic              SO,
    input  logic              nmi_ack,
    output logic              irq_pending,
    output logic              nmi_pending,
    output logic              so_set,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic [DATA_W-1:0] OUTPUT_ENABLE,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              RW,
    output logic              SYNC
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic [DATA_W-1:0]      oe_q, oe_d;
    logic                   rw_q, rw_d;
    logic                   sync_pin_q, sync_pin_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [SYNC_STAGES-1:0] irq_chain_q, irq_chain_d;
    logic [SYNC_STAGES-1:0] nmi_chain_q, nmi_chain_d;
    logic [SYNC_STAGES-1:0] so_chain_q, so_chain_d;
    logic                   nmi_dly_q, nmi_dly_d;
    logic                   so_dly_q, so_dly_d;
    logic                   nmi_pending_q, nmi_pending_d;
    logic                   so_set_q, so_set_d;
    logic                   complete, ready, accept, done, s_nmi, s_so;

    // Bus sequencing: accept a request, hold the pins through wait states, capture read data on completion
    always_comb begin
        complete    = RDY | (~rw_q & (STALL_WRITES == 0));
        ready       = (state_q == IDLE) | complete;
        accept      = core.req_valid & ready;
        done        = (state_q == BUS) & complete;
        state_d     = accept ? BUS : (done ? IDLE : state_q);
        address_d   = accept ? core.req_addr : address_q;
        data_out_d  = accept ? core.req_wdata : data_out_q;
        rw_d        = accept ? ~core.req_write : (done | rw_q);
        sync_pin_d  = accept ? (core.req_fetch & ~core.req_write) : (~done & sync_pin_q);
        oe_d        = accept ? {DATA_W{core.req_write}} : (done ? '0 : oe_q);
        rsp_valid_d = done & rw_q;
        rsp_rdata_d = (done & rw_q) ? DATA_IN : rsp_rdata_q;
    end

    // Interrupt front end: flop chains for metastability, then edge detection on NMI and SO
    always_comb begin
        irq_chain_d   = {irq_chain_q[SYNC_STAGES-2:0], IRQ};
        nmi_chain_d   = {nmi_chain_q[SYNC_STAGES-2:0], NMI};
        so_chain_d    = {so_chain_q[SYNC_STAGES-2:0], SO};
        s_nmi         = nmi_chain_q[SYNC_STAGES-1];
        s_so          = so_chain_q[SYNC_STAGES-1];
        nmi_dly_d     = s_nmi;
        so_dly_d      = s_so;
        nmi_pending_d = (~s_nmi & nmi_dly_q) | (nmi_pending_q & ~nmi_ack);
        so_set_d      = ~s_so & so_dly_q;
    end

    // State registers; reset drops any bus cycle in flight and clears pending events
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            address_q     <= '0;
            data_out_q    <= '0;
            oe_q          <= '0;
            rw_q          <= 1'b1;
            sync_pin_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            irq_chain_q   <= '1;
            nmi_chain_q   <= '1;
            so_chain_q    <= '1;
            nmi_dly_q     <= 1'b1;
            so_dly_q      <= 1'b1;
            nmi_pending_q <= 1'b0;
            so_set_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            data_out_q    <= data_out_d;
            oe_q          <= oe_d;
            rw_q          <= rw_d;
            sync_pin_q    <= sync_pin_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            irq_chain_q   <= irq_chain_d;
            nmi_chain_q   <= nmi_chain_d;
            so_chain_q    <= so_chain_d;
            nmi_dly_q     <= nmi_dly_d;
            so_dly_q      <= so_dly_d;
            nmi_pending_q <= nmi_pending_d;
            so_set_q      <= so_set_d;
        end
    end

    assign core.req_ready = ready;
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_rdata = rsp_rdata_q;
    assign ADDRESS        = address_q;
    assign DATA_OUT       = data_out_q;
    assign OUTPUT_ENABLE  = oe_q;
    assign RW             = rw_q;
    assign SYNC           = sync_pin_q;
    assign irq_pending    = ~irq_chain_q[SYNC_STAGES-1];
    assign nmi_pending    = nmi_pending_q;
    assign so_set         = so_set_q;
endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: directed stimulus with a read-data scoreboard for bus_interface_unit
module tb_bus_interface_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy, irq, nmi, so, nmi_ack;
    logic [7:0] data_in;
    logic [7:0] d0_dout, d0_oe, d1_dout, d1_oe;
    logic [15:0] d0_addr, d1_addr;
    logic d0_rw, d0_sync, d1_rw, d1_sync;
    logic d0_irq, d0_nmi, d0_so, d1_irq, d1_nmi, d1_so;
    int passed = 0;
    int total = 0;
    int rsp_count = 0;
    logic [7:0] sbq[$];

    bus_interface_unit_if #(.DATA_W(8), .ADDR_W(16)) if0 ();
    bus_interface_unit_if #(.DATA_W(8), .ADDR_W(16)) if1 ();

    bus_interface_unit #(.STALL_WRITES(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .core(if0.slave), .RDY(rdy), .IRQ(irq), .NMI(nmi), .SO(so),
        .nmi_ack(nmi_ack), .irq_pending(d0_irq), .nmi_pending(d0_nmi), .so_set(d0_so),
        .DATA_IN(data_in), .DATA_OUT(d0_dout), .OUTPUT_ENABLE(d0_oe), .ADDRESS(d0_addr),
        .RW(d0_rw), .SYNC(d0_sync)
    );

    bus_interface_unit #(.STALL_WRITES(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .core(if1.slave), .RDY(rdy), .IRQ(irq), .NMI(nmi), .SO(so),
        .nmi_ack(nmi_ack), .irq_pending(d1_irq), .nmi_pending(d1_nmi), .so_set(d1_so),
        .DATA_IN(data_in), .DATA_OUT(d1_dout), .OUTPUT_ENABLE(d1_oe), .ADDRESS(d1_addr),
        .RW(d1_rw), .SYNC(d1_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, d0_addr, 0);
        check({tag, "_dout"}, d0_dout, 0);
        check({tag, "_oe"}, d0_oe, 0);
        check({tag, "_sync"}, d0_sync, 0);
        check({tag, "_rw"}, d0_rw, 1);
        check({tag, "_rsp_valid"}, if0.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, if0.rsp_rdata, 0);
        check({tag, "_nmi"}, d0_nmi, 0);
        check({tag, "_so"}, d0_so, 0);
        check({tag, "_ready"}, if0.req_ready, 1);
    endtask

    // Scoreboard: every read response must match the oldest expected data
    always @(negedge clk) begin
        if (rst_n && if0.rsp_valid) begin
            rsp_count++;
            if (sbq.size() == 0) check("rsp_unexpected", if0.rsp_valid, 0);
            else check("rsp_rdata", if0.rsp_rdata, sbq.pop_front());
        end
    end

    // The write-stalling instance only ever sees writes, so it must never respond
    always @(negedge clk) if (rst_n) check("d1_rsp_valid", if1.rsp_valid, 0);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; rdy = 1; irq = 1; nmi = 1; so = 1; nmi_ack = 0; data_in = 0;
        if0.req_valid = 0; if0.req_write = 0; if0.req_fetch = 0; if0.req_addr = 0; if0.req_wdata = 0;
        if1.req_valid = 0; if1.req_write = 0; if1.req_fetch = 0; if1.req_addr = 0; if1.req_wdata = 0;
        cyc(2);
        check_reset_state("reset");
        check("reset_irq", d0_irq, 0);
        rst_n = 1;
        cyc;
        // single read with RDY high
        if0.req_valid = 1; if0.req_addr = 16'h1234; data_in = 8'hA5;
        sbq.push_back(8'hA5);
        #1 check("rd_ready", if0.req_ready, 1);
        cyc;
        check("rd_addr", d0_addr, 16'h1234);
        check("rd_rw", d0_rw, 1);
        check("rd_oe", d0_oe, 8'h00);
        check("rd_sync", d0_sync, 0);
        check("rd_rsp_early", if0.rsp_valid, 0);
        if0.req_valid = 0;
        cyc;
        check("rd_rsp", if0.rsp_valid, 1);
        check("rd_rdata", if0.rsp_rdata, 8'hA5);
        // opcode fetch with three wait states
        if0.req_valid = 1; if0.req_fetch = 1; if0.req_addr = 16'h8000; rdy = 0; data_in = 8'h3C;
        sbq.push_back(8'h3C);
        cyc;
        for (int i = 0; i < 4; i++) begin
            check("fetch_sync", d0_sync, 1);
            check("fetch_addr", d0_addr, 16'h8000);
            check("fetch_ready", if0.req_ready, 0);
            check("fetch_rsp_early", if0.rsp_valid, 0);
            if (i == 0) begin if0.req_valid = 0; if0.req_fetch = 0; end
            if (i == 3) rdy = 1;
            cyc;
        end
        check("fetch_rsp", if0.rsp_valid, 1);
        check("fetch_sync_end", d0_sync, 0);
        // write with RDY low on both stall policies
        rdy = 0;
        if0.req_valid = 1; if0.req_write = 1; if0.req_addr = 16'h0200; if0.req_wdata = 8'h5A;
        if1.req_valid = 1; if1.req_write = 1; if1.req_addr = 16'h0200; if1.req_wdata = 8'h5A;
        cyc;
        check("wr_rw", d0_rw, 0);
        check("wr_oe", d0_oe, 8'hFF);
        check("wr_dout", d0_dout, 8'h5A);
        check("wr_addr", d0_addr, 16'h0200);
        check("wr_ready", if0.req_ready, 1);
        check("wr1_rw", d1_rw, 0);
        check("wr1_ready", if1.req_ready, 0);
        if0.req_valid = 0; if0.req_write = 0; if1.req_valid = 0; if1.req_write = 0;
        cyc;
        check("wr_done_rw", d0_rw, 1);
        check("wr_done_oe", d0_oe, 8'h00);
        check("wr_done_dout", d0_dout, 8'h5A);
        check("wr1_hold_rw", d1_rw, 0);
        check("wr1_hold_oe", d1_oe, 8'hFF);
        cyc;
        check("wr1_hold2_rw", d1_rw, 0);
        check("wr1_hold2_dout", d1_dout, 8'h5A);
        rdy = 1;
        cyc;
        check("wr1_done_rw", d1_rw, 1);
        check("wr1_done_oe", d1_oe, 8'h00);
        // four back-to-back reads
        if0.req_valid = 1; if0.req_addr = 16'h0010;
        cyc;
        for (int i = 0; i < 4; i++) begin
            check("b2b_addr", d0_addr, 16'h0010 + i);
            check("b2b_rw", d0_rw, 1);
            check("b2b_rsp", if0.rsp_valid, 32'(i > 0));
            check("b2b_ready", if0.req_ready, 1);
            data_in = 8'hC0 + 8'(i);
            sbq.push_back(data_in);
            if (i < 3) if0.req_addr = 16'h0011 + 16'(i);
            else if0.req_valid = 0;
            cyc;
        end
        check("b2b_rsp_last", if0.rsp_valid, 1);
        cyc;
        check("b2b_idle_rw", d0_rw, 1);
        check("b2b_idle_rsp", if0.rsp_valid, 0);
        // IRQ level path
        irq = 0;
        cyc;
        check("irq_t1", d0_irq, 0);
        cyc;
        check("irq_t2", d0_irq, 1);
        irq = 1;
        cyc;
        check("irq_rel1", d0_irq, 1);
        cyc;
        check("irq_rel2", d0_irq, 0);
        // SO held low gives one pulse
        so = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc;
            check("so_set", d0_so, 32'(i == 3));
        end
        so = 1;
        cyc(3);
        // NMI held low, acknowledged, then re-triggered coinciding with ack
        nmi = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc;
            check("nmi_pending", d0_nmi, 32'(i >= 3));
        end
        nmi_ack = 1;
        cyc;
        check("nmi_ack_clear", d0_nmi, 0);
        nmi_ack = 0;
        for (int i = 0; i < 3; i++) begin
            cyc;
            check("nmi_no_reset", d0_nmi, 0);
        end
        nmi = 1;
        cyc(4);
        nmi = 0;
        cyc(2);
        nmi_ack = 1;
        cyc;
        check("nmi_set_wins", d0_nmi, 1);
        nmi_ack = 0; nmi = 1;
        cyc;
        check("nmi_latched", d0_nmi, 1);
        // reset in the middle of a stalled read
        if0.req_valid = 1; if0.req_fetch = 1; if0.req_addr = 16'h4444; rdy = 0;
        cyc;
        check("rst_pre_addr", d0_addr, 16'h4444);
        check("rst_pre_sync", d0_sync, 1);
        if0.req_valid = 0; if0.req_fetch = 0;
        cyc;
        #2 rst_n = 0;
        #1 check_reset_state("rst_mid");
        rdy = 1;
        cyc(2);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc;
            check("post_rst_rsp", if0.rsp_valid, 0);
            check("post_rst_rw", d0_rw, 1);
            check("post_rst_oe", d0_oe, 0);
            check("post_rst_sync", d0_sync, 0);
        end
        check("sb_empty", sbq.size(), 0);
        check("rsp_count", rsp_count, 6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Parametrised external-bus and interrupt front end for the tinymos6502 core family. It sits between the core's internal sequencer and the chip pins. It turns single-beat core requests into registered pin-level bus cycles, and honours RDY wait states with a selectable read-only or read-and-write stall policy. It also synchronises the asynchronous IRQ, NMI and SO inputs and edge-detects them. Data and address widths are parameters, so the same block serves the 8/16-bit core and wider derivatives.

## Interface
Parameters:
- DATA_W, default 8: data bus width.
- ADDR_W, default 16: address bus width.
- SYNC_STAGES, default 2, minimum 2: synchroniser depth on IRQ, NMI and SO.
- STALL_WRITES, default 0: 0 means RDY stalls reads only (NMOS behaviour); 1 means RDY stalls reads and writes.

Ports (clock and reset first):
- CLK, in, 1: single clock; all logic is on the rising edge.
- RST_N, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: core presents a bus request.
- req_ready, out, 1: the request is accepted on this edge when req_valid=1.
- req_write, in, 1: 1 = write, 0 = read.
- req_fetch, in, 1: the read is an opcode fetch; drives SYNC.
- req_addr, in, ADDR_W: request address.
- req_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: one-cycle pulse carrying read data.
- rsp_rdata, out, DATA_W: captured read data; holds its value between pulses.
- RDY, in, 1: wait-state input; it is synchronous to CLK and is not synchronised.
- IRQ, in, 1: asynchronous, active low, level-sensitive.
- NMI, in, 1: asynchronous, active low, falling-edge-sensitive.
- SO, in, 1: asynchronous, active low, falling-edge-sensitive.
- nmi_ack, in, 1: the core clears nmi_pending.
- irq_pending, out, 1: synchronised IRQ level, active high.
- nmi_pending, out, 1: latched NMI edge.
- so_set, out, 1: one-cycle pulse on an SO falling edge.
- DATA_IN, in, DATA_W: pin input data.
- DATA_OUT, out, DATA_W: pin output data.
- OUTPUT_ENABLE, out, DATA_W: 1 = pin driven.
- ADDRESS, out, ADDR_W: pin address.
- RW, out, 1: 1 = read, 0 = write.
- SYNC, out, 1: high during an opcode-fetch cycle.

## Operation
- Two states: IDLE and BUS.
- Accept: a request is accepted when req_valid && req_ready.
  - The state moves to BUS.
  - The pins are registered from the request: ADDRESS=req_addr, RW=~req_write, SYNC=req_fetch & ~req_write, DATA_OUT=req_wdata, OUTPUT_ENABLE = all ones for a write and all zeros for a read.
- Completion: `complete` = RDY | (~RW & ~STALL_WRITES). While in BUS with complete=0, every pin holds its value (stall).
- At the completing edge:
  - A read captures DATA_IN into rsp_rdata and drives rsp_valid=1 for the following cycle. A write produces no response.
- Ready rule: req_ready = IDLE | (BUS & complete). This is a combinational path from RDY, and it allows back-to-back cycles.
  - If there is no new request at completion, the state returns to IDLE.
  - In IDLE: RW=1, SYNC=0, OUTPUT_ENABLE=0. ADDRESS and DATA_OUT hold their last values.
- Synchronisers: a SYNC_STAGES-deep flop chain on each of IRQ, NMI and SO, reset to 1 (inactive). Call the chain output s.
  - irq_pending = ~s_irq.
  - nmi_pending: set by s_nmi falling relative to its delayed copy, cleared by nmi_ack. If an edge and nmi_ack occur in the same cycle, set wins.
  - so_set: registered pulse on the s_so falling edge.
  - A held-low NMI or SO gives exactly one event; a new event needs the input to return high first.
- Reset values:
  - 0: ADDRESS, DATA_OUT, OUTPUT_ENABLE, SYNC, rsp_valid, rsp_rdata, nmi_pending, so_set.
  - 1: RW, req_ready.
  - The state resets to IDLE.
  - Asserting reset mid-cycle drops the bus cycle with no rsp_valid, and clears pending events.

## Timing
- Accept edge E0 → pins valid in the cycle after E0.
- With RDY=1, a read completes at E1 and rsp_valid is high after E1: latency 2 edges from accept to response.
- Throughput: one bus cycle per clock with RDY=1.
- Each RDY=0 cycle adds exactly one cycle to a read. It adds one cycle to a write only when STALL_WRITES=1.
- IRQ low → irq_pending high after SYNC_STAGES edges.
- NMI or SO falling → nmi_pending or so_set high after SYNC_STAGES+1 edges.
- The IRQ, NMI and SO paths are independent of the bus state.

## Test plan
- Read at 0x1234, RDY=1, DATA_IN=0xA5 → pins ADDRESS=0x1234, RW=1, OE=0x00 for one cycle; rsp_valid one cycle later with rsp_rdata=0xA5.
- Read with req_fetch=1 and RDY low for 3 cycles → SYNC=1 and the pins are held for 4 cycles; exactly one rsp_valid; req_ready stays low during the stall.
- Write 0x5A to 0x0200 with RDY=0, STALL_WRITES=0 → one cycle with RW=0, OE=0xFF, DATA_OUT=0x5A; no rsp_valid. With STALL_WRITES=1, the same write holds until RDY=1.
- Four back-to-back reads with req_valid held high and RDY=1 → four consecutive bus cycles and four consecutive rsp_valid pulses with the matching data.
- NMI held low for 10 cycles → nmi_pending rises after 3 edges (default SYNC_STAGES) and stays high.
  - nmi_ack clears it with no re-set while NMI is still low.
  - A new falling edge coinciding with nmi_ack leaves nmi_pending=1.
- RST_N asserted during a stalled read → all outputs at their reset values immediately; after release, no rsp_valid and IDLE pin state.
